cr16_control_fsm: RTL and testbench

Multicycle control unit for the 16-bit CR16-subset datapath. It decodes the latched instruction word (`instrOut`) and the processor status flags (`PSROut`) and sequences every datapath enable and mux select through fetch, decode, execute, memory and write-back. It also drives the memory write strobe. It is the only block that advances the program counter or writes the register file.

---
 rtl/cr16_pkg.sv | 83 ++++++++
 rtl/cr16_cond_eval.sv | 45 ++++
 rtl/cr16_control_fsm.sv | 186 ++++++++++++++++++
 tb/tb_cr16_control_fsm.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cr16_pkg.sv
// Shared definitions for the CR16-subset control unit: state encoding,
// opcode/opext codes, condition codes, PSR bit positions, result-mux codes.
package cr16_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_LATCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_WB     = 4'd7,
        S_BRANCH = 4'd8
    } state_t;

    // Major opcodes (instr[15:12]); immediate ALU forms reuse the opext code
    localparam logic [3:0] OP_REG   = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_XORI  = 4'b0011;
    localparam logic [3:0] OP_MEM   = 4'b0100;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_BCOND = 4'b1100;
    localparam logic [3:0] OP_LUI   = 4'b1111;

    // ALU codes (opext for register form, op for immediate form)
    localparam logic [3:0] EXT_AND  = 4'b0001;
    localparam logic [3:0] EXT_OR   = 4'b0010;
    localparam logic [3:0] EXT_XOR  = 4'b0011;
    localparam logic [3:0] EXT_ADD  = 4'b0101;
    localparam logic [3:0] EXT_ADDU = 4'b0110;
    localparam logic [3:0] EXT_ADDC = 4'b0111;
    localparam logic [3:0] EXT_SUB  = 4'b1001;
    localparam logic [3:0] EXT_SUBC = 4'b1010;
    localparam logic [3:0] EXT_CMP  = 4'b1011;
    localparam logic [3:0] EXT_MOV  = 4'b1101;

    // opext codes under OP_MEM and OP_SHIFT
    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;
    localparam logic [3:0] EXT_JCOND = 4'b1100;
    localparam logic [3:0] EXT_LSH   = 4'b0100;

    // Condition codes (instr[11:8] of Bcond/Jcond)
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_GT = 4'b0110;
    localparam logic [3:0] COND_LE = 4'b0111;
    localparam logic [3:0] COND_FS = 4'b1000;
    localparam logic [3:0] COND_FC = 4'b1001;
    localparam logic [3:0] COND_LO = 4'b1010;
    localparam logic [3:0] COND_HS = 4'b1011;
    localparam logic [3:0] COND_UC = 4'b1110;

    // PSR bit positions
    localparam int PSR_C = 0;
    localparam int PSR_L = 2;
    localparam int PSR_F = 5;
    localparam int PSR_Z = 6;
    localparam int PSR_N = 7;

    // chooseResult encodings
    localparam logic [1:0] RES_SHIFT = 2'd0;
    localparam logic [1:0] RES_ALU   = 2'd1;
    localparam logic [1:0] RES_PC    = 2'd2;
    localparam logic [1:0] RES_LINK  = 2'd3;

    // True for every defined ALU operation code
    function automatic logic is_alu_code(input logic [3:0] c);
        return c inside {EXT_AND, EXT_OR, EXT_XOR, EXT_ADD, EXT_ADDU, EXT_ADDC,
                         EXT_SUB, EXT_SUBC, EXT_CMP, EXT_MOV};
    endfunction

    // Only the arithmetic compare-capable ops update the status flags
    function automatic logic sets_flags(input logic [3:0] c);
        return c inside {EXT_ADD, EXT_SUB, EXT_CMP};
    endfunction

endpackage

// File: rtl/cr16_cond_eval.sv
// Branch/jump condition evaluator. With CTRL_CONDBR_EN defined the full
// condition table is evaluated against the PSR; otherwise only the
// unconditional code is taken and the PSR is ignored.
module cr16_cond_eval
    import cr16_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [7:0] psr,
    output logic       taken
);

`ifdef CTRL_CONDBR_EN
    // PSR bits that no condition looks at
    logic unused_psr_bits;
    assign unused_psr_bits = ^{psr[4:3], psr[1]};

    // Full condition table; unlisted codes are never taken
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = psr[PSR_Z];
            COND_NE: taken = !psr[PSR_Z];
            COND_CS: taken = psr[PSR_C];
            COND_CC: taken = !psr[PSR_C];
            COND_GT: taken = psr[PSR_N];
            COND_LE: taken = !psr[PSR_N];
            COND_FS: taken = psr[PSR_F];
            COND_FC: taken = !psr[PSR_F];
            COND_LO: taken = !psr[PSR_L] && !psr[PSR_Z];
            COND_HS: taken = psr[PSR_L] || psr[PSR_Z];
            COND_UC: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end
`else
    logic unused_psr;
    assign unused_psr = ^psr;

    // Reduced build: only the unconditional code is taken
    always_comb begin
        taken = (cond == COND_UC);
    end
`endif

endmodule

// File: rtl/cr16_control_fsm.sv
// Multicycle control unit for the CR16-subset datapath. Sequences fetch,
// decode, execute, memory and write-back, and drives every datapath enable.
// Conditional branch evaluation is enabled by defining CTRL_CONDBR_EN.
module cr16_control_fsm
    import cr16_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   instrOut,
    input  logic [7:0]         PSROut,
    output logic               PCEN,
    output logic               PSREN,
    output logic               nextInstruction,
    output logic               updateAddress,
    output logic               StoreReg,
    output logic               WriteData,
    output logic               regWrite,
    output logic               ZeroExtend,
    output logic               PCinstruction,
    output logic               regDest,
    output logic               SrcB,
    output logic               resultEn,
    output logic               immediateRegEN,
    output logic               jumpEN,
    output logic               BranchEN,
    output logic               jalEN,
    output logic [REGBITS-1:0] shiftAmt,
    output logic [REGBITS-1:0] shifterControl,
    output logic [REGBITS-1:0] ALUcond,
    output logic [1:0]         chooseResult,
    output logic               memWrite,
    output logic [3:0]         state
);

    state_t state_q, state_d;

    // Instruction fields
    logic [3:0] op, rdest, opext, rsrc, alu_code;
    assign op    = instrOut[WIDTH-1 -: 4];
    assign rdest = instrOut[WIDTH-5 -: 4];
    assign opext = instrOut[7:4];
    assign rsrc  = instrOut[3:0];

    // Instruction class decode
    logic is_alu_reg, is_alu_imm, is_shift_reg, is_shift_imm;
    logic is_alu, is_shift, is_reg_form, is_cmp;
    logic is_load, is_stor, is_jal, is_jcond, is_bcond, is_branch;
    logic cond_taken, taken;

    assign is_alu_reg   = (op == OP_REG) && is_alu_code(opext);
    assign is_alu_imm   = is_alu_code(op) || (op == OP_LUI);
    assign is_shift_reg = (op == OP_SHIFT) && (opext == EXT_LSH);
    assign is_shift_imm = (op == OP_SHIFT) && (opext[3:1] == 3'b000);
    assign is_alu       = is_alu_reg || is_alu_imm;
    assign is_shift     = is_shift_reg || is_shift_imm;
    assign is_reg_form  = is_alu_reg || is_shift_reg;
    assign alu_code     = (op == OP_REG) ? opext : op;
    assign is_cmp       = is_alu && (alu_code == EXT_CMP);
    assign is_load      = (op == OP_MEM) && (opext == EXT_LOAD);
    assign is_stor      = (op == OP_MEM) && (opext == EXT_STOR);
    assign is_jal       = (op == OP_MEM) && (opext == EXT_JAL);
    assign is_jcond     = (op == OP_MEM) && (opext == EXT_JCOND);
    assign is_bcond     = (op == OP_BCOND);
    assign is_branch    = is_jal || is_jcond || is_bcond;

    cr16_cond_eval u_cond (
        .cond  (rdest),
        .psr   (PSROut),
        .taken (cond_taken)
    );

    // JAL is unconditional; Bcond/Jcond use the evaluated condition
    assign taken = is_jal || cond_taken;
    assign state = state_q;

    // State register with synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode; every output defaults to 0
    always_comb begin
        state_d         = S_FETCH;
        PCEN            = 1'b0;
        PSREN           = 1'b0;
        nextInstruction = 1'b0;
        updateAddress   = 1'b0;
        StoreReg        = 1'b0;
        WriteData       = 1'b0;
        regWrite        = 1'b0;
        ZeroExtend      = 1'b0;
        PCinstruction   = 1'b0;
        regDest         = 1'b0;
        SrcB            = 1'b0;
        resultEn        = 1'b0;
        immediateRegEN  = 1'b0;
        jumpEN          = 1'b0;
        BranchEN        = 1'b0;
        jalEN           = 1'b0;
        shiftAmt        = '0;
        shifterControl  = '0;
        ALUcond         = '0;
        chooseResult    = RES_SHIFT;
        memWrite        = 1'b0;
        case (state_q)
            S_FETCH: begin
                updateAddress = 1'b1;
                state_d       = S_LATCH;
            end
            S_LATCH: begin
                updateAddress   = 1'b1;
                nextInstruction = 1'b1;
                state_d         = S_DECODE;
            end
            S_DECODE: begin
                // pc+1 through the PC unit, and capture the immediate
                PCinstruction  = 1'b1;
                PCEN           = 1'b1;
                immediateRegEN = 1'b1;
                ZeroExtend     = op inside {OP_ANDI, OP_ORI, OP_XORI};
                if (is_alu || is_shift) state_d = S_EXEC;
                else if (is_load)       state_d = S_MEMRD;
                else if (is_stor)       state_d = S_MEMWR;
                else if (is_branch)     state_d = S_BRANCH;
                else                    state_d = S_FETCH;
            end
            S_EXEC: begin
                resultEn = 1'b1;
                SrcB     = is_reg_form;
                if (is_shift) begin
                    chooseResult   = RES_SHIFT;
                    shiftAmt       = rsrc;
                    shifterControl = opext;
                end else begin
                    chooseResult = RES_ALU;
                    ALUcond      = alu_code;
                    PSREN        = sets_flags(alu_code);
                end
                state_d = is_cmp ? S_FETCH : S_WB;
            end
            S_WB: begin
                WriteData = 1'b1;
                regWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMRD: begin
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                regWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                StoreReg = 1'b1;
                memWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                if (taken) begin
                    PCinstruction = 1'b1;
                    PCEN          = 1'b1;
                    if (is_jal) begin
                        jalEN        = 1'b1;
                        chooseResult = RES_LINK;
                        regDest      = 1'b1;
                        regWrite     = 1'b1;
                    end else if (is_jcond) begin
                        jumpEN = 1'b1;
                    end else begin
                        BranchEN = 1'b1;
                    end
                end
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_cr16_control_fsm.sv
// Directed bench for cr16_control_fsm: per-cycle expected control vectors
// are queued for each instruction and popped as the FSM steps.
module tb_cr16_control_fsm;
    import cr16_pkg::*;

`ifdef CTRL_CONDBR_EN
    localparam bit COND_FULL = 1'b1;
`else
    localparam bit COND_FULL = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] st;
        logic pcen, psren, nexti, upda, storereg, wdata, regwrite, zext;
        logic pcinstr, regdest, srcb, resen, immen, jumpen, branchen, jalen;
        logic [3:0] shamt, shctl, alucond;
        logic [1:0] chres;
        logic       memwrite;
    } ctrl_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instrOut;
    logic [7:0]  PSROut;
    logic PCEN, PSREN, nextInstruction, updateAddress, StoreReg, WriteData;
    logic regWrite, ZeroExtend, PCinstruction, regDest, SrcB, resultEn;
    logic immediateRegEN, jumpEN, BranchEN, jalEN, memWrite;
    logic [3:0] shiftAmt, shifterControl, ALUcond, state;
    logic [1:0] chooseResult;

    cr16_control_fsm #(.WIDTH(16), .REGBITS(4)) dut (
        .clk(clk), .reset(reset), .instrOut(instrOut), .PSROut(PSROut),
        .PCEN(PCEN), .PSREN(PSREN), .nextInstruction(nextInstruction),
        .updateAddress(updateAddress), .StoreReg(StoreReg), .WriteData(WriteData),
        .regWrite(regWrite), .ZeroExtend(ZeroExtend), .PCinstruction(PCinstruction),
        .regDest(regDest), .SrcB(SrcB), .resultEn(resultEn),
        .immediateRegEN(immediateRegEN), .jumpEN(jumpEN), .BranchEN(BranchEN),
        .jalEN(jalEN), .shiftAmt(shiftAmt), .shifterControl(shifterControl),
        .ALUcond(ALUcond), .chooseResult(chooseResult), .memWrite(memWrite),
        .state(state)
    );

    always #5 clk = ~clk;

    ctrl_t obs;
    assign obs = {state, PCEN, PSREN, nextInstruction, updateAddress, StoreReg,
                  WriteData, regWrite, ZeroExtend, PCinstruction, regDest, SrcB,
                  resultEn, immediateRegEN, jumpEN, BranchEN, jalEN, shiftAmt,
                  shifterControl, ALUcond, chooseResult, memWrite};

    ctrl_t exp_q[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    int    last_mw;

    task automatic check(input string tag, input ctrl_t got, input ctrl_t expv);
        n_cmp++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%h required=%h", tag, got, expv);
        end
    endtask

    task automatic check_val(input string tag, input int got, input int expv);
        n_cmp++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d required=%0d", tag, got, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic ctrl_t blank(input logic [3:0] st);
        ctrl_t c;
        c = '0;
        c.st = st;
        return c;
    endfunction

    function automatic ctrl_t fetch_exp();
        ctrl_t c;
        c = blank(4'd0);
        c.upda = 1'b1;
        return c;
    endfunction

    // FETCH, LATCH, DECODE are common to every instruction
    task automatic push_front_end(input logic zext);
        ctrl_t c;
        exp_q.push_back(fetch_exp());
        c = blank(4'd1); c.upda = 1'b1; c.nexti = 1'b1;
        exp_q.push_back(c);
        c = blank(4'd2); c.pcinstr = 1'b1; c.pcen = 1'b1; c.immen = 1'b1; c.zext = zext;
        exp_q.push_back(c);
    endtask

    task automatic push_exec_alu(input logic srcb, input logic [3:0] alucond, input logic psren);
        ctrl_t c;
        c = blank(4'd3); c.resen = 1'b1; c.srcb = srcb; c.alucond = alucond;
        c.chres = 2'd1; c.psren = psren;
        exp_q.push_back(c);
    endtask

    task automatic push_exec_shift(input logic srcb, input logic [3:0] shamt, input logic [3:0] shctl);
        ctrl_t c;
        c = blank(4'd3); c.resen = 1'b1; c.srcb = srcb; c.shamt = shamt;
        c.shctl = shctl; c.chres = 2'd0;
        exp_q.push_back(c);
    endtask

    task automatic push_wb();
        ctrl_t c;
        c = blank(4'd7); c.wdata = 1'b1; c.regwrite = 1'b1;
        exp_q.push_back(c);
    endtask

    // kind: 0 Bcond, 1 Jcond, 2 JAL
    task automatic push_branch(input int kind, input logic tk);
        ctrl_t c;
        c = blank(4'd8);
        if (tk) begin
            c.pcinstr = 1'b1; c.pcen = 1'b1;
            if (kind == 0) c.branchen = 1'b1;
            else if (kind == 1) c.jumpen = 1'b1;
            else begin
                c.jalen = 1'b1; c.chres = 2'd3; c.regdest = 1'b1; c.regwrite = 1'b1;
            end
        end
        exp_q.push_back(c);
    endtask

    // Drive one instruction, compare each queued cycle, then expect FETCH
    task automatic run(input string tag, input logic [15:0] instr, input logic [7:0] psr,
                       input int reset_at);
        int    n;
        ctrl_t e;
        instrOut = instr;
        PSROut   = psr;
        n        = exp_q.size();
        last_mw  = 0;
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            check($sformatf("%s.cyc%0d", tag, i), obs, e);
            if (memWrite === 1'b1) last_mw++;
            if (i == reset_at) reset = 1'b1;
            step();
            reset = 1'b0;
        end
        check($sformatf("%s.back_to_fetch", tag), obs, fetch_exp());
        $display("[tb] %-10s instr=%h psr=%h cycles=%0d", tag, instr, psr, n);
    endtask

    // Bcond condition table: code, PSR, taken when full evaluation is built in
    logic [3:0] t_cond [15] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'h8,
                                4'h9, 4'hA, 4'hA, 4'hB, 4'hE, 4'h4, 4'hF};
    logic [7:0] t_psr  [15] = '{8'h40, 8'h00, 8'h00, 8'h01, 8'h01, 8'h80, 8'h80, 8'h20,
                                8'h20, 8'h00, 8'h04, 8'h40, 8'h00, 8'hFF, 8'hFF};
    logic       t_take [15] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                                1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        instrOut = 16'h0000;
        PSROut   = 8'h00;
        step();
        step();
        check("reset_state", obs, fetch_exp());
        reset = 1'b0;

        // ADD r1,r3
        push_front_end(1'b0); push_exec_alu(1'b1, 4'b0101, 1'b1); push_wb();
        run("ADD", 16'h0153, 8'h00, -1);

        // ANDI r2,#7 : zero-extended immediate, no flag update
        push_front_end(1'b1); push_exec_alu(1'b0, 4'b0001, 1'b0); push_wb();
        run("ANDI", 16'h1207, 8'h00, -1);

        // SUBI r3,#5
        push_front_end(1'b0); push_exec_alu(1'b0, 4'b1001, 1'b1); push_wb();
        run("SUBI", 16'h9305, 8'h00, -1);

        // CMP r1,r3 : no write-back, 4 cycles
        push_front_end(1'b0); push_exec_alu(1'b1, 4'b1011, 1'b1);
        run("CMP", 16'h01B3, 8'h00, -1);

        // LSHI r2,#3 and LSH r2,r3
        push_front_end(1'b0); push_exec_shift(1'b0, 4'h3, 4'b0000); push_wb();
        run("LSHI", 16'h8203, 8'h00, -1);
        push_front_end(1'b0); push_exec_shift(1'b1, 4'h3, 4'b0100); push_wb();
        run("LSH", 16'h8243, 8'h00, -1);

        // LOAD r2,[r4]
        push_front_end(1'b0);
        exp_q.push_back(blank(4'd4));
        begin ctrl_t c; c = blank(4'd5); c.regwrite = 1'b1; exp_q.push_back(c); end
        run("LOAD", 16'h4204, 8'h00, -1);

        // STOR : single-cycle write strobe
        push_front_end(1'b0);
        begin ctrl_t c; c = blank(4'd6); c.storereg = 1'b1; c.memwrite = 1'b1; exp_q.push_back(c); end
        run("STOR", 16'h4144, 8'h00, -1);
        check_val("STOR.memwrite_cycles", last_mw, 1);

        // BEQ with Z set / clear
        push_front_end(1'b0); push_branch(0, COND_FULL);
        run("BEQ_Z1", 16'hC0FE, 8'h40, -1);
        push_front_end(1'b0); push_branch(0, 1'b0);
        run("BEQ_Z0", 16'hC0FE, 8'h00, -1);

        // JAL r15 : always taken, link written
        push_front_end(1'b0); push_branch(2, 1'b1);
        run("JAL", 16'h4F8A, 8'h00, -1);

        // JNE r2 with Z clear
        push_front_end(1'b0); push_branch(1, COND_FULL);
        run("JNE", 16'h41C2, 8'h00, -1);

        // Unconditional jump
        push_front_end(1'b0); push_branch(1, 1'b1);
        run("JUC", 16'h4EC5, 8'h40, -1);

        // Undefined opcodes behave as NOP after DECODE
        push_front_end(1'b0);
        run("UNDEF_E", 16'hE123, 8'h00, -1);
        push_front_end(1'b0);
        run("UNDEF_0", 16'h0003, 8'h00, -1);

        // Condition code table via Bcond
        for (int k = 0; k < 15; k++) begin
            logic [15:0] ins;
            logic        tk;
            ins = {4'hC, t_cond[k], 8'h10};
            tk  = COND_FULL ? t_take[k] : (t_cond[k] == 4'hE);
            push_front_end(1'b0); push_branch(0, tk);
            run($sformatf("BCOND%0d", k), ins, t_psr[k], -1);
        end

        // Reset asserted during EXEC of ADD: next cycle is a clean FETCH
        push_front_end(1'b0); push_exec_alu(1'b1, 4'b0101, 1'b1);
        run("RST_EXEC", 16'h0153, 8'h00, 3);
        check_val("RST_EXEC.regWrite", int'(regWrite), 0);
        check_val("RST_EXEC.PSREN", int'(PSREN), 0);

        // Normal operation resumes after the reset
        push_front_end(1'b0); push_exec_alu(1'b1, 4'b0101, 1'b1); push_wb();
        run("ADD_AGAIN", 16'h0153, 8'h00, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
